dmi_core_access_ctrl: RTL

Core-clock DMI access controller sitting directly downstream of the JTAG-to-core synchronizer. It consumes the single-cycle `reg_en`/`reg_wr_en` pulses together with the quasi-static address and write data from the JTAG DTM. It runs one valid/ready request and response transaction per pulse toward the debug module. It returns read data and a sticky RISC-V-style op status to the JTAG side.

---
 rtl/dmi_pkg.sv | 18 +
 rtl/dmi_rsp_timer.sv | 24 ++
 rtl/dmi_core_access_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared types and encodings for the core-side DMI access controller.
package dmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } dmi_state_e;

  localparam logic [1:0] DMI_OK     = 2'd0;
  localparam logic [1:0] DMI_FAILED = 2'd2;
  localparam logic [1:0] DMI_BUSY   = 2'd3;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;
  localparam int DMI_TMO_W  = 8;

endpackage

// File: rtl/dmi_rsp_timer.sv
// Response timeout counter; expire fires on the cycle the count reaches all-ones.
module dmi_rsp_timer #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_inc;

  assign cnt_inc = cnt + TMO_W'(1);
  assign expire  = en && (cnt_inc == '1);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt_inc;
  end

endmodule

// File: rtl/dmi_core_access_ctrl.sv
// Turns synchronized JTAG DMI access pulses into one valid/ready request and
// response transaction each, returning read data and a sticky op status.
module dmi_core_access_ctrl
  import dmi_pkg::*;
#(
  parameter int ADDR_W = DMI_ADDR_W,
  parameter int DATA_W = DMI_DATA_W,
  parameter int TMO_W  = DMI_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_en,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              status_clr,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic              dmi_req_write,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [DATA_W-1:0] dmi_req_wdata,
  input  logic              dmi_rsp_valid,
  input  logic [DATA_W-1:0] dmi_rsp_rdata,
  input  logic              dmi_rsp_err,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        status,
  output logic              busy
);

  dmi_state_e        state, state_n;
  logic              req_valid_n, req_write_n;
  logic [ADDR_W-1:0] req_addr_n;
  logic [DATA_W-1:0] req_wdata_n, rdata_n;
  logic [1:0]        status_n;
  logic              tmr_clr, tmr_en, tmr_expire;

  dmi_rsp_timer #(.TMO_W(TMO_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_n     = state;
    req_valid_n = dmi_req_valid;
    req_write_n = dmi_req_write;
    req_addr_n  = dmi_req_addr;
    req_wdata_n = dmi_req_wdata;
    rdata_n     = rdata;
    // clear is applied before any new error so a same-cycle failure survives
    status_n    = status_clr ? DMI_OK : status;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reg_en && status_n == DMI_OK) begin
          req_valid_n = 1'b1;
          req_write_n = reg_wr_en;
          req_addr_n  = reg_addr;
          req_wdata_n = reg_wdata;
          state_n     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (reg_en) status_n = DMI_BUSY;
        if (dmi_req_ready) begin
          req_valid_n = 1'b0;
          tmr_clr     = 1'b1;
          state_n     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (reg_en) status_n = DMI_BUSY;
        tmr_en = 1'b1;
        if (dmi_rsp_valid) begin
          if (dmi_rsp_err)         status_n = DMI_FAILED;
          else if (!dmi_req_write) rdata_n  = dmi_rsp_rdata;
          state_n = ST_IDLE;
        end else if (tmr_expire) begin
          status_n = DMI_FAILED;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dmi_req_valid <= 1'b0;
      dmi_req_write <= 1'b0;
      dmi_req_addr  <= '0;
      dmi_req_wdata <= '0;
      rdata         <= '0;
      status        <= DMI_OK;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      dmi_req_valid <= req_valid_n;
      dmi_req_write <= req_write_n;
      dmi_req_addr  <= req_addr_n;
      dmi_req_wdata <= req_wdata_n;
      rdata         <= rdata_n;
      status        <= status_n;
      busy          <= (state_n != ST_IDLE);
    end
  end

endmodule
